mw_rxbuf_reader: RTL and testbench
==================================

Name: mw_rxbuf_reader

Overview:
- Drains the packet processor's RX buffer read port, one byte per read with a 1-cycle read latency.
- Parses a 3-byte header: byte0 = channel id, bytes1-2 = payload length (big-endian).
- Delivers the payload as a ready/valid byte stream tagged with the channel id to the DUT-side demux.
- Malformed or unroutable packets are discarded and counted. Single clock domain, dutclk.

Parameters:
- DATAWIDTH, 8, byte width of the buffer and output data; fixed at 8 by the header format.
- NUMCHANNELS, 4, number of valid channel ids (0..NUMCHANNELS-1); range 1..255.
- CNTWIDTH, 16, width of the packet and drop counters.

Ports:
- dutclk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rxbuffer_rden  out  1  read strobe to the RX buffer.
- rxbuffer_data  in  DATAWIDTH  byte returned 1 cycle after rden.
- rxbuffer_datavld  in  1  qualifies rxbuffer_data.
- rxbuffer_eop  in  1  last byte of a packet; qualified by datavld.
- rxbuffer_empty  in  1  buffer has no data.
- out_data  out  DATAWIDTH  payload byte.
- out_chan  out  8  channel id of the current packet.
- out_valid  out  1  out_data, out_chan and out_last are valid.
- out_last  out  1  last payload byte of the packet.
- out_ready  in  1  consumer accepts the byte when valid && ready.
- err_pulse  out  1  1-cycle pulse on any drop or truncation.
- pkt_count  out  CNTWIDTH  packets delivered with at least 1 byte; saturating.
- drop_count  out  CNTWIDTH  packets dropped or truncated; saturating.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM in IDLE, skid buffer empty, counters 0.
- Read issue: rxbuffer_rden = !rxbuffer_empty && (skid_occupancy + inflight < 2).
  - inflight = rden registered 1 cycle.
  - Reads are not throttled in header or DROP states; only payload bytes enter the skid buffer.
- Skid buffer: 2 entries, each holding {data, chan, last}. out_* driven from the head entry.
- Output latency: payload byte to out_valid is 1 cycle after the datavld cycle.
- FSM (advances only on datavld):
  - IDLE: wait for the first byte, which is the channel id. Then go to HDR_LH and latch chan_q.
  - HDR_LH: latch len[15:8], go to HDR_LL.
  - HDR_LL: latch len[7:0].
    - len=0 with eop: packet consumed, no output, no count, go to IDLE.
    - len=0 without eop: go to DROP, drop_count+1, err_pulse.
    - chan_q >= NUMCHANNELS: go to DROP, drop_count+1, err_pulse.
    - otherwise: remaining = len, go to PAYLOAD.
  - PAYLOAD: push each byte; remaining decrements.
    - remaining=1 with eop: push last=1, pkt_count+1, go to IDLE.
    - eop with remaining>1 (short packet): push last=1, pkt_count+1, drop_count+1, err_pulse, go to IDLE.
    - remaining=1 without eop (long packet): push last=1, pkt_count+1, drop_count+1, err_pulse, go to DROP.
  - DROP: discard bytes until eop, then go to IDLE.
- eop during any HDR state (runt):
  - If chan already latched or not, discard and go to IDLE; drop_count+1, err_pulse.
  - In HDR_LL, eop takes this runt path for any len except the len=0-with-eop case above.
- Eop on the IDLE byte (1-byte packet): runt, drop_count+1, err_pulse, remain in IDLE.
- Counters saturate at all-ones. A cycle that increments both counters does so in the same cycle.
- Simultaneous push and pop on the skid buffer: occupancy unchanged, order preserved. No byte is lost under any out_ready pattern.
- out_valid never deasserts without a handshake. out_data, out_chan and out_last are stable while valid && !ready.

Decomposition:
- Package mw_rxbuf_reader_pkg:
  - FSM state enum (IDLE, HDR_LH, HDR_LL, PAYLOAD, DROP).
  - HDR_BYTES=3.
  - Channel id width constant CHANW=8.
- Sub-module mw_rxbuf_skid: 2-entry FIFO with push, pop, occupancy, and a {data, chan, last} payload.

Test Plan:
- Packet {02,00,03,AA,BB,CC(eop)}, out_ready=1 → out: AA, BB, CC(last) with chan=2; pkt_count=1; no err_pulse.
- Same packet with out_ready toggling 1-0-0-1 → identical byte sequence; rden never issued with occupancy+inflight ≥ 2; no byte lost.
- Packet {07,00,02,11,22(eop)} with NUMCHANNELS=4 → no out_valid; drop_count=1; one err_pulse.
- Short packet {01,00,05,11,22(eop)} → 11, 22(last); pkt_count=1; drop_count=1. Long packet {01,00,01,33,44,55(eop)} → 33(last) only; 44 and 55 discarded.
- Runt {03,00(eop)} followed by a valid packet {00,00,01,5A(eop)} → the runt is counted as a drop; 5A(last) is delivered with chan=0.
- reset asserted mid-PAYLOAD with 2 bytes in the skid buffer → all outputs 0 immediately; after release a new packet is parsed from IDLE correctly.

Source files
------------

// File: rtl/mw_rxbuf_reader_pkg.sv
// mw_rxbuf_reader_pkg: shared types and constants for the RX buffer reader
package mw_rxbuf_reader_pkg;
    localparam int HDR_BYTES = 3;
    localparam int CHANW = 8;
    localparam int DW = 8;
    localparam int LENW = DW * (HDR_BYTES - 1);
    typedef enum logic [2:0] {IDLE, HDR_LH, HDR_LL, PAYLOAD, DROP} state_t;
    typedef struct packed {
        logic [DW-1:0]    data;
        logic [CHANW-1:0] chan;
        logic             last;
    } entry_t;
endpackage

// File: rtl/mw_rxbuf_skid.sv
// mw_rxbuf_skid: 2-entry FIFO holding {data, chan, last} payload entries
module mw_rxbuf_skid
    import mw_rxbuf_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  entry_t     entry_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic       valid_o,
    output logic [1:0] occ_o
);
    entry_t     mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    // a push and a pop in the same cycle leave the occupancy unchanged
    always_comb cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    // entry storage with independent write and read pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end
    assign head_o  = mem_q[rd_q];
    assign valid_o = cnt_q != 2'd0;
    assign occ_o   = cnt_q;
endmodule

// File: rtl/mw_rxbuf_reader.sv
// mw_rxbuf_reader: parses RX buffer packets and streams routable payload bytes
module mw_rxbuf_reader
    import mw_rxbuf_reader_pkg::*;
#(
    parameter int DATAWIDTH   = 8,
    parameter int NUMCHANNELS = 4,
    parameter int CNTWIDTH    = 16
) (
    input  logic                 dutclk,
    input  logic                 reset,
    output logic                 rxbuffer_rden,
    input  logic [DATAWIDTH-1:0] rxbuffer_data,
    input  logic                 rxbuffer_datavld,
    input  logic                 rxbuffer_eop,
    input  logic                 rxbuffer_empty,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [CHANW-1:0]     out_chan,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 err_pulse,
    output logic [CNTWIDTH-1:0]  pkt_count,
    output logic [CNTWIDTH-1:0]  drop_count
);
    localparam logic [CHANW-1:0] NCH = CHANW'(NUMCHANNELS);
    state_t               state_q;
    logic [CHANW-1:0]     chan_q;
    logic [DATAWIDTH-1:0] len_hi_q;
    logic [LENW-1:0]      rem_q;
    logic [LENW-1:0]      len_d;
    logic                 inflight_q;
    logic                 err_q;
    logic [CNTWIDTH-1:0]  pkt_q;
    logic [CNTWIDTH-1:0]  drop_q;
    logic [1:0]           occ;
    logic                 rem_one;
    logic                 push;
    logic                 pop;
    logic                 pkt_inc;
    logic                 drop_inc;
    entry_t               entry_d;
    entry_t               head;
    // classify the returned byte: what it pushes and which counters it bumps
    always_comb begin
        len_d    = {len_hi_q, rxbuffer_data};
        rem_one  = rem_q == LENW'(1);
        push     = rxbuffer_datavld && state_q == PAYLOAD;
        entry_d  = '{data: rxbuffer_data, chan: chan_q, last: rxbuffer_eop || rem_one};
        pkt_inc  = push && (rxbuffer_eop || rem_one);
        drop_inc = rxbuffer_datavld && (
                   (state_q == IDLE    && rxbuffer_eop) ||
                   (state_q == HDR_LH  && rxbuffer_eop) ||
                   (state_q == HDR_LL  && (rxbuffer_eop ? len_d != '0 : (len_d == '0 || chan_q >= NCH))) ||
                   (state_q == PAYLOAD && rxbuffer_eop != rem_one));
    end
    // reads only when every outstanding byte is guaranteed a skid slot
    assign rxbuffer_rden = reset && !rxbuffer_empty && (occ + {1'b0, inflight_q}) < 2'd2;
    assign pop = out_valid && out_ready;
    // header parser, payload tracking and saturating statistics
    always_ff @(posedge dutclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            len_hi_q   <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            pkt_q      <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= rxbuffer_rden;
            err_q      <= drop_inc;
            pkt_q      <= pkt_q + {{(CNTWIDTH-1){1'b0}}, pkt_inc && !(&pkt_q)};
            drop_q     <= drop_q + {{(CNTWIDTH-1){1'b0}}, drop_inc && !(&drop_q)};
            if (rxbuffer_datavld) begin
                case (state_q)
                    IDLE: begin
                        chan_q  <= rxbuffer_data;
                        state_q <= rxbuffer_eop ? IDLE : HDR_LH;
                    end
                    HDR_LH: begin
                        len_hi_q <= rxbuffer_data;
                        state_q  <= rxbuffer_eop ? IDLE : HDR_LL;
                    end
                    HDR_LL: begin
                        rem_q   <= len_d;
                        state_q <= rxbuffer_eop ? IDLE : (len_d == '0 || chan_q >= NCH) ? DROP : PAYLOAD;
                    end
                    PAYLOAD: begin
                        rem_q   <= rem_q - LENW'(1);
                        state_q <= rxbuffer_eop ? IDLE : rem_one ? DROP : PAYLOAD;
                    end
                    DROP: state_q <= rxbuffer_eop ? IDLE : DROP;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    mw_rxbuf_skid u_skid (
        .clk_i   (dutclk),
        .rst_ni  (reset),
        .push_i  (push),
        .entry_i (entry_d),
        .pop_i   (pop),
        .head_o  (head),
        .valid_o (out_valid),
        .occ_o   (occ)
    );
    assign out_data   = head.data;
    assign out_chan   = head.chan;
    assign out_last   = head.last;
    assign err_pulse  = err_q;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_mw_rxbuf_reader.sv
// tb_mw_rxbuf_reader: scoreboard bench with a packet-level reference model
module tb_mw_rxbuf_reader;
    typedef logic [7:0] bq_t[$];
    typedef struct {logic [7:0] d; logic eop;} rxb_t;
    typedef struct {logic [7:0] d; logic [7:0] c; logic l;} out_t;

    logic        dutclk = 1'b0;
    logic        reset = 1'b0;
    logic        rxbuffer_rden;
    logic [7:0]  rxbuffer_data;
    logic        rxbuffer_datavld;
    logic        rxbuffer_eop;
    logic        rxbuffer_empty;
    logic [7:0]  out_data;
    logic [7:0]  out_chan;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        err_pulse;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    rxb_t buf_q[$];
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_pkt = 0;
    int   exp_drop = 0;
    int   err_seen = 0;
    int   ready_mode = 0;
    int   ready_ph = 0;
    logic [3:0] pat = 4'b1001;
    logic drv_rd;
    logic drv_got;
    rxb_t drv_e;
    logic held = 1'b0;
    out_t hold;
    out_t mexp;

    always #5 dutclk = ~dutclk;

    mw_rxbuf_reader #(.DATAWIDTH(8), .NUMCHANNELS(4), .CNTWIDTH(16)) dut (
        .dutclk           (dutclk),
        .reset            (reset),
        .rxbuffer_rden    (rxbuffer_rden),
        .rxbuffer_data    (rxbuffer_data),
        .rxbuffer_datavld (rxbuffer_datavld),
        .rxbuffer_eop     (rxbuffer_eop),
        .rxbuffer_empty   (rxbuffer_empty),
        .out_data         (out_data),
        .out_chan         (out_chan),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .err_pulse        (err_pulse),
        .pkt_count        (pkt_count),
        .drop_count       (drop_count)
    );

    // Packet-level model: decides the fate of a whole packet from its length and header
    task automatic send_pkt(input bq_t b);
        int n;
        int len;
        int p;
        int m;
        n = b.size();
        len = (n >= 3) ? int'({b[1], b[2]}) : 0;
        if (n < 3 || (n == 3 && len != 0)) exp_drop++;
        else if (n > 3) begin
            if (len == 0 || b[0] >= 8'd4) exp_drop++;
            else begin
                p = n - 3;
                m = (p < len) ? p : len;
                for (int i = 0; i < m; i++) exp_q.push_back('{b[3+i], b[0], logic'(i == m - 1)});
                exp_pkt++;
                if (p != len) exp_drop++;
            end
        end
        for (int i = 0; i < n; i++) buf_q.push_back('{b[i], logic'(i == n - 1)});
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((buf_q.size() != 0 || exp_q.size() != 0) && t < 5000) begin
            @(negedge dutclk);
            t++;
        end
        repeat (6) @(negedge dutclk);
        check({tag, "_timeout"}, int'(t >= 5000), 0);
        check({tag, "_pkt_count"}, int'(pkt_count), exp_pkt);
        check({tag, "_drop_count"}, int'(drop_count), exp_drop);
        check({tag, "_err_pulses"}, err_seen, exp_drop);
        check({tag, "_idle_valid"}, int'(out_valid), 0);
    endtask

    // RX buffer model: a read strobe returns the next byte one cycle later
    initial begin
        rxbuffer_datavld = 1'b0;
        rxbuffer_data = 8'h00;
        rxbuffer_eop = 1'b0;
        rxbuffer_empty = 1'b1;
        forever begin
            @(negedge dutclk);
            drv_rd = rxbuffer_rden;
            drv_got = 1'b0;
            if (drv_rd) begin
                checks++;
                if (buf_q.size() == 0) begin
                    errors++;
                    $display("FAIL rden_when_empty: got rden=1 want rden=0");
                end else begin
                    drv_e = buf_q.pop_front();
                    drv_got = 1'b1;
                end
            end
            @(posedge dutclk);
            #1;
            rxbuffer_datavld = drv_got;
            rxbuffer_data = drv_got ? drv_e.d : 8'h00;
            rxbuffer_eop = drv_got && drv_e.eop;
            rxbuffer_empty = buf_q.size() == 0;
        end
    end

    // consumer back-pressure patterns
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge dutclk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[ready_ph];
                    ready_ph = (ready_ph + 1) % 4;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // monitor: pops the scoreboard on each handshake and checks stall stability
    initial begin
        forever begin
            @(negedge dutclk);
            if (!reset) held = 1'b0;
            else begin
                if (err_pulse) err_seen++;
                if (held) begin
                    checks++;
                    if (!out_valid || out_data != hold.d || out_chan != hold.c || out_last != hold.l) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h c=%h l=%b want v=1 d=%h c=%h l=%b",
                                 out_valid, out_data, out_chan, out_last, hold.d, hold.c, hold.l);
                    end
                end
                held = 1'b0;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got d=%h c=%h l=%b want none", out_data, out_chan, out_last);
                    end else begin
                        mexp = exp_q.pop_front();
                        if (out_data != mexp.d || out_chan != mexp.c || out_last != mexp.l) begin
                            errors++;
                            $display("FAIL out_byte: got d=%h c=%h l=%b want d=%h c=%h l=%b",
                                     out_data, out_chan, out_last, mexp.d, mexp.c, mexp.l);
                        end
                    end
                end else if (out_valid) begin
                    held = 1'b1;
                    hold = '{out_data, out_chan, out_last};
                end
            end
        end
    end

    initial begin
        int t;
        #1;
        check("rst_rden", int'(rxbuffer_rden), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_err", int'(err_pulse), 0);
        check("rst_pkt", int'(pkt_count), 0);
        check("rst_drop", int'(drop_count), 0);
        #22 reset = 1'b1;
        repeat (2) @(negedge dutclk);

        ready_mode = 0;
        send_pkt('{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        drain("basic");

        ready_mode = 1;
        send_pkt('{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        drain("toggle");

        ready_mode = 0;
        send_pkt('{8'h07, 8'h00, 8'h02, 8'h11, 8'h22});
        drain("badchan");

        send_pkt('{8'h01, 8'h00, 8'h05, 8'h11, 8'h22});
        send_pkt('{8'h01, 8'h00, 8'h01, 8'h33, 8'h44, 8'h55});
        drain("shortlong");

        send_pkt('{8'h03, 8'h00});
        send_pkt('{8'h00, 8'h00, 8'h01, 8'h5A});
        send_pkt('{8'h09});
        send_pkt('{8'h01, 8'h00, 8'h00});
        send_pkt('{8'h01, 8'h00, 8'h00, 8'h77});
        drain("runt");

        ready_mode = 2;
        for (int k = 0; k < 60; k++) begin
            bq_t p;
            int npl;
            p = {};
            p.push_back(8'($urandom_range(0, 5)));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) p.push_back(8'($urandom_range(0, 255)));
            end else begin
                p.push_back(8'h00);
                p.push_back(8'($urandom_range(0, 6)));
                npl = $urandom_range(0, 7);
                for (int i = 0; i < npl; i++) p.push_back(8'($urandom_range(0, 255)));
            end
            send_pkt(p);
        end
        drain("random");

        ready_mode = 3;
        send_pkt('{8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge dutclk);
            t++;
        end
        check("midrst_wait_valid", int'(out_valid), 1);
        repeat (4) @(negedge dutclk);
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_data", int'(out_data), 0);
        check("midrst_chan", int'(out_chan), 0);
        check("midrst_last", int'(out_last), 0);
        check("midrst_rden", int'(rxbuffer_rden), 0);
        check("midrst_pkt", int'(pkt_count), 0);
        check("midrst_drop", int'(drop_count), 0);
        exp_q.delete();
        buf_q.delete();
        exp_pkt = 0;
        exp_drop = 0;
        err_seen = 0;
        repeat (3) @(negedge dutclk);
        #2 reset = 1'b1;
        ready_mode = 0;
        repeat (2) @(negedge dutclk);
        send_pkt('{8'h02, 8'h00, 8'h02, 8'hAB, 8'hCD});
        drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
